safety_data_mem_responder: RTL

// - OBI-style responder (req/gnt/rvalid) serving the safety core's data port from a word-wide SRAM.
// - Sits between the core data master and the local data SRAM macro. Core-side protocol has no rready.
// - Flags accesses outside the window with err_o, and logs the first failing address and a count.

---
 rtl/safety_island_pkg.sv | 13 +
 rtl/safety_resp_pipe.sv | 29 ++
 rtl/safety_data_mem_responder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/safety_island_pkg.sv
// Shared types and constants for the safety island data-side responder.
// The response meta record travels alongside each granted transfer.
package safety_island_pkg;

    typedef struct packed {
        logic valid;
        logic err;
        logic we;
    } resp_meta_t;

    localparam logic [31:0] DataRespErrVal = 32'hBADCAB1E;

endpackage

// File: rtl/safety_resp_pipe.sv
// Fixed-depth shift register of response meta records.
// Exactly one push and one pop per cycle, so the pipe cannot overflow.
module safety_resp_pipe
    import safety_island_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  resp_meta_t push_i,
    output resp_meta_t pop_o
);

    resp_meta_t [Depth-1:0] meta_pipe;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_pipe <= '0;
        end else begin
            meta_pipe[0] <= push_i;
            for (int i = 1; i < Depth; i++) begin
                meta_pipe[i] <= meta_pipe[i-1];
            end
        end
    end

    assign pop_o = meta_pipe[Depth-1];

endmodule

// File: rtl/safety_data_mem_responder.sv
// OBI-style responder between the safety core data port and its word-wide SRAM.
// Out-of-window accesses are answered locally with an error and logged.
module safety_data_mem_responder
    import safety_island_pkg::*;
#(
    parameter logic [31:0] BaseAddr    = 32'h0000_0000,
    parameter int unsigned NumWords    = 4096,
    parameter int unsigned ReadLatency = 1,
    parameter int unsigned ErrCntWidth = 8,
    localparam int unsigned AddrWidth  = $clog2(NumWords)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic                   we_i,
    input  logic [3:0]             be_i,
    input  logic [31:0]            addr_i,
    input  logic [31:0]            wdata_i,
    output logic                   rvalid_o,
    output logic [31:0]            rdata_o,
    output logic                   err_o,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic                   mem_we_o,
    output logic [3:0]             mem_be_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [31:0]            mem_wdata_o,
    input  logic [31:0]            mem_rdata_i,
    output logic [31:0]            err_addr_o,
    output logic [ErrCntWidth-1:0] err_cnt_o,
    input  logic                   err_clear_i
);

    logic [32:0]    addr_ext;
    logic [32:0]    win_lo;
    logic [32:0]    win_hi;
    logic           hit;
    logic [31:0]    word_off;
    logic           unused_off;
    logic           miss_gnt;
    resp_meta_t     push_meta;
    resp_meta_t     resp_meta;

    // 33-bit compare so a window ending at 4 GiB does not wrap
    assign addr_ext = {1'b0, addr_i};
    assign win_lo   = {1'b0, BaseAddr};
    assign win_hi   = win_lo + (33'(NumWords) << 2);
    assign hit      = (addr_ext >= win_lo) && (addr_ext < win_hi);

    assign mem_req_o = req_i && hit;
    assign gnt_o     = req_i && (hit ? mem_gnt_i : 1'b1);
    assign miss_gnt  = req_i && !hit;

    // SRAM side is quiet when no access is requested
    assign word_off    = addr_i - BaseAddr;
    assign mem_addr_o  = mem_req_o ? word_off[AddrWidth+1:2] : '0;
    assign mem_we_o    = mem_req_o & we_i;
    assign mem_be_o    = mem_req_o ? be_i : '0;
    assign mem_wdata_o = mem_req_o ? wdata_i : '0;
    assign unused_off  = ^{word_off[31:AddrWidth+2], word_off[1:0]};

    always_comb begin
        push_meta = '0;
        if (gnt_o) begin
            push_meta.valid = 1'b1;
            push_meta.err   = !hit;
            push_meta.we    = we_i;
        end
    end

    safety_resp_pipe #(
        .Depth (ReadLatency)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (push_meta),
        .pop_o  (resp_meta)
    );

    assign rvalid_o = resp_meta.valid;
    assign err_o    = resp_meta.valid & resp_meta.err;

    always_comb begin
        rdata_o = '0;
        if (resp_meta.valid) begin
            if (resp_meta.err) begin
                rdata_o = DataRespErrVal;
            end else if (!resp_meta.we) begin
                rdata_o = mem_rdata_i;
            end
        end
    end

    logic                   err_lock_q;
    logic [ErrCntWidth-1:0] err_cnt_q;
    logic [31:0]            err_addr_q;

    // A clear coinciding with a miss restarts the log at that miss
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_lock_q <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else if (miss_gnt) begin
            if (err_clear_i) begin
                err_cnt_q <= ErrCntWidth'(1);
            end else if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + ErrCntWidth'(1);
            end
            if (err_clear_i || !err_lock_q) begin
                err_addr_q <= addr_i;
            end
            err_lock_q <= 1'b1;
        end else if (err_clear_i) begin
            err_cnt_q  <= '0;
            err_lock_q <= 1'b0;
        end
    end

    assign err_cnt_o  = err_cnt_q;
    assign err_addr_o = err_addr_q;

endmodule
